led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
//
// PURPOSE
//  Multi-channel LED pattern generator. Successor to the single free-running
//  LED blink counter in the display top level. Each channel has a runtime mode
//  (off/on/blink/breathe) and a runtime half-period, loaded over a valid/ready
//  config port. Runs in the pixel-clock domain and drives board LEDs directly.
//
// PARAMETERS
//  CHANNELS      4         number of LED channels (1..16)
//  CNT_W         32        width of per-channel half-period / phase counters
//  PRESCALE      25200     PCLK cycles per TICK (>=1; 1 => TICK every cycle)
//  PWM_W         8         breathe PWM resolution in bits
//  DEFAULT_MODE  2'b10     per-channel mode after reset
//  DEFAULT_HALF  400       per-channel half-period (in ticks) after reset
//
// PORTS
//  PCLK        in   1                 pixel clock, all logic on rising edge
//  RESET_n     in   1                 async active-low reset
//  CFG_VALID   in   1                 config write request
//  CFG_READY   out  1                 config port can accept
//  CFG_CH      in   4                 target channel index
//  CFG_MODE    in   2                 00 off, 01 on, 10 blink, 11 breathe
//  CFG_HALF    in   CNT_W             half-period in ticks (0 treated as 1)
//  CFG_ERR     out  1                 1-cycle pulse: accepted write, CFG_CH>=CHANNELS
//  TICK        out  1                 1-cycle prescaler strobe
//  LED         out  CHANNELS          registered LED drive, bit i = channel i
//
// BEHAVIOUR
//  Reset (async assert, sync release): LED=0, TICK=0, CFG_ERR=0, CFG_READY=1,
//   prescaler=0, all phase=0, duty=0, dir=up, mode=DEFAULT_MODE, half=DEFAULT_HALF.
//  Prescaler: counts 0..PRESCALE-1, wraps; TICK=1 for the cycle after the edge
//   where count==PRESCALE-1 (registered). Mid-count reset restarts from 0.
//  Per-channel phase: on TICK, phase increments; when phase==max(half,1)-1 on
//   a TICK, phase->0 and a channel "wrap" event fires. Modes off/on still count.
//  Modes (LED registered, one cycle after the state driving it):
//   off: LED=0.  on: LED=1.  blink: LED toggles on each wrap.
//   breathe: free-running PWM_W-bit pwm counter (shared, every cycle);
//   LED=(pwm<duty). On each wrap duty steps +1 (dir up) or -1 (dir down);
//   at 2^PWM_W-1 dir->down, at 0 dir->up (triangle, no hold at extremes).
//  Config handshake: write accepted on edge where CFG_VALID&&CFG_READY.
//   At accept edge: mode/half of CFG_CH written, its phase=0, duty=0, dir=up,
//   blink LED state cleared; CFG_READY=0 for exactly the next cycle, then 1
//   (max one write per 2 cycles). Inputs need only be stable at accept edge.
//  Accept latency: new mode visible on LED one edge after accept edge.
//  Invalid channel (CFG_CH>=CHANNELS): accepted, no state change, CFG_ERR=1
//   for one cycle; CFG_READY handling identical.
//  Simultaneous TICK and accept on same channel: config wins, tick ignored for
//   that channel; other channels advance normally.
//  half change takes effect only via config (phase cleared), never mid-count.
//  All counter arithmetic unsigned, wraps modulo 2^width; phase never exceeds
//   half-1 so no overflow in normal use.
//
// TESTING  (CHANNELS=4, CNT_W=8, PRESCALE=4, PWM_W=4, DEFAULT_HALF=3)
//  Release reset, no config -> TICK every 4 cycles; all LEDs blink in phase,
//   toggling every 12 cycles (24-cycle period), first toggle 13 cycles after release.
//  Write ch1 mode=01 -> LED[1]=1 one cycle after accept; CFG_READY low 1 cycle;
//   LED[0,2,3] pattern undisturbed.
//  Back-to-back CFG_VALID held 4 cycles (ch0 off, ch2 off) -> exactly 2 accepts,
//   2 cycles apart; LED[0],LED[2]=0 afterwards.
//  Write ch3 mode=11 half=1 -> duty steps each TICK 0..15..0; over a pwm period
//   LED[3] high count == duty; full triangle repeats every 120 cycles.
//  Write CFG_CH=7 -> CFG_ERR one-cycle pulse, no LED/config change.
//  Write with half=0 -> behaves as half=1; assert RESET_n low mid-blink ->
//   LED=0 immediately (async), restart matches scenario 1.

Source files
------------

// File: rtl/led_pattern_gen.sv
`timescale 1ns/1ps
// led_pattern_gen: multi-channel LED driver. Each channel can be off, on, blink or breathe.
// Each channel's mode and half-period are loaded at runtime over a valid/ready config port.
module led_pattern_gen #(
  parameter int          CHANNELS     = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRESCALE     = 25200,
  parameter int          PWM_W        = 8,
  parameter logic [1:0]  DEFAULT_MODE = 2'b10,
  parameter int unsigned DEFAULT_HALF = 400
) (
  input  logic                PCLK,
  input  logic                RESET_n,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  input  logic [3:0]          CFG_CH,
  input  logic [1:0]          CFG_MODE,
  input  logic [CNT_W-1:0]    CFG_HALF,
  output logic                CFG_ERR,
  output logic                TICK,
  output logic [CHANNELS-1:0] LED
);

  localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [PWM_W-1:0] DUTY_TOP = '1;
  localparam logic [4:0]       CH_LIMIT = 5'(CHANNELS);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  typedef enum logic {
    CFG_IDLE,
    CFG_HOLD
  } cfg_state_t;

  cfg_state_t          cfg_state;
  logic [PS_W-1:0]     presc_q;
  logic [PWM_W-1:0]    pwm_q;

  mode_t               mode_q     [CHANNELS];
  logic [CNT_W-1:0]    half_q     [CHANNELS];
  logic [CNT_W-1:0]    phase_q    [CHANNELS];
  logic [CNT_W-1:0]    phase_last [CHANNELS];
  logic [PWM_W-1:0]    duty_q     [CHANNELS];
  logic [CHANNELS-1:0] dir_down;
  logic [CHANNELS-1:0] blink_q;
  logic [CHANNELS-1:0] cfg_hit;
  logic [CHANNELS-1:0] wrap;

  logic accept;
  logic ch_invalid;

  assign accept     = CFG_VALID && CFG_READY;
  assign ch_invalid = ({1'b0, CFG_CH} >= CH_LIMIT);

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      presc_q <= '0;
      TICK    <= 1'b0;
      pwm_q   <= '0;
    end else begin
      TICK    <= (presc_q == PS_LAST);
      presc_q <= (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
      pwm_q   <= pwm_q + PWM_W'(1);
    end
  end

  // One accepted write per two cycles: READY drops for the cycle after every accept.
  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cfg_state <= CFG_IDLE;
      CFG_READY <= 1'b1;
      CFG_ERR   <= 1'b0;
    end else begin
      CFG_ERR <= 1'b0;
      case (cfg_state)
        CFG_IDLE: begin
          if (CFG_VALID) begin
            cfg_state <= CFG_HOLD;
            CFG_READY <= 1'b0;
            CFG_ERR   <= ch_invalid;
          end
        end
        CFG_HOLD: begin
          cfg_state <= CFG_IDLE;
          CFG_READY <= 1'b1;
        end
        default: begin
          cfg_state <= CFG_IDLE;
          CFG_READY <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cfg_hit = '0;
    wrap    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      phase_last[i] = (half_q[i] == '0) ? '0 : half_q[i] - CNT_W'(1);
      cfg_hit[i]    = accept && (CFG_CH == 4'(i));
      wrap[i]       = TICK && !cfg_hit[i] && (phase_q[i] == phase_last[i]);
    end
  end

  // A config write to a channel overrides any tick landing on that same edge.
  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_t'(DEFAULT_MODE);
        half_q[i]  <= HALF_RST;
        phase_q[i] <= '0;
        duty_q[i]  <= '0;
      end
      dir_down <= '0;
      blink_q  <= '0;
      LED      <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_hit[i]) begin
          mode_q[i]   <= mode_t'(CFG_MODE);
          half_q[i]   <= CFG_HALF;
          phase_q[i]  <= '0;
          duty_q[i]   <= '0;
          dir_down[i] <= 1'b0;
          blink_q[i]  <= 1'b0;
        end else if (wrap[i]) begin
          phase_q[i] <= '0;
          blink_q[i] <= ~blink_q[i];
          if (!dir_down[i]) begin
            duty_q[i] <= duty_q[i] + PWM_W'(1);
            if (duty_q[i] == DUTY_TOP - PWM_W'(1)) dir_down[i] <= 1'b1;
          end else begin
            duty_q[i] <= duty_q[i] - PWM_W'(1);
            if (duty_q[i] == PWM_W'(1)) dir_down[i] <= 1'b0;
          end
        end else if (TICK) begin
          phase_q[i] <= phase_q[i] + CNT_W'(1);
        end

        case (mode_q[i])
          MODE_OFF:     LED[i] <= 1'b0;
          MODE_ON:      LED[i] <= 1'b1;
          MODE_BLINK:   LED[i] <= blink_q[i] ^ wrap[i];
          MODE_BREATHE: LED[i] <= (pwm_q < duty_q[i]);
          default:      LED[i] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
`timescale 1ns/1ps
// tb_led_pattern_gen: constant vector table, corner-case sequences and randomized config
// traffic, all compared against an arithmetic model of tick, wrap and duty counts.
module tb_led_pattern_gen;

  logic       PCLK      = 1'b0;
  logic       RESET_n   = 1'b0;
  logic       CFG_VALID = 1'b0;
  logic [3:0] CFG_CH    = 4'd0;
  logic [1:0] CFG_MODE  = 2'd0;
  logic [7:0] CFG_HALF  = 8'd0;
  logic       CFG_READY;
  logic       CFG_ERR;
  logic       TICK;
  logic [3:0] LED;

  led_pattern_gen #(
    .CHANNELS(4), .CNT_W(8), .PRESCALE(4), .PWM_W(4),
    .DEFAULT_MODE(2'b10), .DEFAULT_HALF(3)
  ) dut (
    .PCLK(PCLK), .RESET_n(RESET_n), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_CH(CFG_CH), .CFG_MODE(CFG_MODE), .CFG_HALF(CFG_HALF), .CFG_ERR(CFG_ERR),
    .TICK(TICK), .LED(LED)
  );

  always #5 PCLK = ~PCLK;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Model state: edges since reset release, and per channel the edge of the last
  // two configs (reset counts as a config at edge 0) with their mode and half.
  int         edge_n;
  logic       model_ready;
  logic       exp_err;
  int         cur_c  [4];
  int         prev_c [4];
  int         cur_h  [4];
  int         prev_h [4];
  logic [1:0] cur_m  [4];
  logic [1:0] prev_m [4];

  typedef struct {
    logic       v;
    logic [3:0] ch;
    logic [1:0] mode;
    logic [7:0] half;
    logic [3:0] led;
    logic       tick;
    logic       ready;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t idleVec(input logic [3:0] led, input logic tick);
    idleVec = '{1'b0, 4'd0, 2'd0, 8'd0, led, tick, 1'b1};
  endfunction

  // TICK is high after edges 4, 8, ..., so it is consumed at edges 5, 9, ...
  function automatic int tcount(input int u);
    return (u >= 1) ? (u - 1) / 4 : 0;
  endfunction

  function automatic int triangle(input int w);
    int r;
    r = w % 30;
    return (r <= 15) ? r : 30 - r;
  endfunction

  function automatic logic [3:0] model_led(input int e);
    logic [3:0] r;
    int         c, h, up, w;
    logic [1:0] m;
    r = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (cur_c[i] < e) begin
        c = cur_c[i]; m = cur_m[i]; h = cur_h[i]; up = e;
      end else begin
        c = prev_c[i]; m = prev_m[i]; h = prev_h[i]; up = e - 1;
      end
      case (m)
        2'b00: r[i] = 1'b0;
        2'b01: r[i] = 1'b1;
        2'b10: begin
          w    = (tcount(up) - tcount(c)) / h;
          r[i] = (w % 2) == 1;
        end
        default: begin
          w    = (tcount(e - 1) - tcount(c)) / h;
          r[i] = ((e - 1) % 16) < triangle(w);
        end
      endcase
    end
    return r;
  endfunction

  function automatic void modelReset();
    edge_n      = 0;
    model_ready = 1'b1;
    exp_err     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cur_c[i] = 0; cur_m[i] = 2'b10; cur_h[i] = 3;
      prev_c[i] = 0; prev_m[i] = 2'b10; prev_h[i] = 3;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_n, actual, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] ch, input logic [1:0] m, input logic [7:0] h);
    logic acc;
    int   k;
    CFG_VALID = v;
    CFG_CH    = ch;
    CFG_MODE  = m;
    CFG_HALF  = h;
    acc = v && model_ready;
    @(posedge PCLK);
    #1;
    edge_n++;
    exp_err     = acc && (ch >= 4'd4);
    model_ready = !acc;
    if (acc && ch < 4'd4) begin
      k = int'(ch);
      prev_c[k] = cur_c[k]; prev_m[k] = cur_m[k]; prev_h[k] = cur_h[k];
      cur_c[k]  = edge_n;   cur_m[k]  = m;        cur_h[k]  = (h == 8'd0) ? 1 : int'(h);
    end
    checkOutput("led",   LED,           model_led(edge_n));
    checkOutput("tick",  4'(TICK),      4'((edge_n >= 4) && (edge_n % 4 == 0)));
    checkOutput("ready", 4'(CFG_READY), 4'(model_ready));
    checkOutput("err",   4'(CFG_ERR),   4'(exp_err));
    CFG_VALID = 1'b0;
  endtask

  task automatic runTable(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(vecs[k].v, vecs[k].ch, vecs[k].mode, vecs[k].half);
      checkOutput("vec_led",   LED,           vecs[k].led);
      checkOutput("vec_tick",  4'(TICK),      4'(vecs[k].tick));
      checkOutput("vec_ready", 4'(CFG_READY), 4'(vecs[k].ready));
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_led"},   LED,           4'h0);
    checkOutput({tag, "_tick"},  4'(TICK),      4'h0);
    checkOutput({tag, "_ready"}, 4'(CFG_READY), 4'h1);
    checkOutput({tag, "_err"},   4'(CFG_ERR),   4'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         ready_lows;
    int         breathe_edge;
    logic       rv;
    logic [3:0] rch;
    logic [1:0] rm;
    logic [7:0] rh;

    // Default blink, half=3, prescale 4: first toggle at edge 13, then every 12 edges.
    // Edge 15 writes ch1 mode=on; at edge 25 the other channels fall back to 0.
    vecs[0]  = idleVec(4'h0, 1'b0); vecs[1]  = idleVec(4'h0, 1'b0); vecs[2]  = idleVec(4'h0, 1'b0);
    vecs[3]  = idleVec(4'h0, 1'b1); vecs[4]  = idleVec(4'h0, 1'b0); vecs[5]  = idleVec(4'h0, 1'b0);
    vecs[6]  = idleVec(4'h0, 1'b0); vecs[7]  = idleVec(4'h0, 1'b1); vecs[8]  = idleVec(4'h0, 1'b0);
    vecs[9]  = idleVec(4'h0, 1'b0); vecs[10] = idleVec(4'h0, 1'b0); vecs[11] = idleVec(4'h0, 1'b1);
    vecs[12] = idleVec(4'hF, 1'b0); vecs[13] = idleVec(4'hF, 1'b0);
    vecs[14] = '{1'b1, 4'd1, 2'b01, 8'd3, 4'hF, 1'b0, 1'b0};
    vecs[15] = idleVec(4'hF, 1'b1); vecs[16] = idleVec(4'hF, 1'b0); vecs[17] = idleVec(4'hF, 1'b0);
    vecs[18] = idleVec(4'hF, 1'b0); vecs[19] = idleVec(4'hF, 1'b1); vecs[20] = idleVec(4'hF, 1'b0);
    vecs[21] = idleVec(4'hF, 1'b0); vecs[22] = idleVec(4'hF, 1'b0); vecs[23] = idleVec(4'hF, 1'b1);
    vecs[24] = idleVec(4'h2, 1'b0);

    modelReset();
    RESET_n = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checkResetState("reset");
    RESET_n = 1'b1;
    runTable(25);

    ready_lows = 0;
    applyStimulus(1'b1, 4'd0, 2'b00, 8'd3); if (!CFG_READY) ready_lows++;
    applyStimulus(1'b1, 4'd0, 2'b00, 8'd3); if (!CFG_READY) ready_lows++;
    applyStimulus(1'b1, 4'd2, 2'b00, 8'd3); if (!CFG_READY) ready_lows++;
    applyStimulus(1'b1, 4'd2, 2'b00, 8'd3); if (!CFG_READY) ready_lows++;
    checkOutput("b2b_accepts", 4'(ready_lows), 4'd2);
    repeat (3) applyStimulus(1'b0, 4'd0, 2'b00, 8'd0);
    checkOutput("b2b_off", {2'b00, LED[2], LED[0]}, 4'h0);

    applyStimulus(1'b1, 4'd3, 2'b11, 8'd1);
    breathe_edge = edge_n;
    applyStimulus(1'b0, 4'd0, 2'b00, 8'd0);
    checkOutput("breathe_start", 4'(LED[3]), 4'h0);
    while (edge_n < breathe_edge + 130) applyStimulus(1'b0, 4'd0, 2'b00, 8'd0);

    applyStimulus(1'b1, 4'd7, 2'b01, 8'd2);
    checkOutput("err_pulse", 4'(CFG_ERR), 4'h1);
    applyStimulus(1'b0, 4'd0, 2'b00, 8'd0);
    checkOutput("err_clear", 4'(CFG_ERR), 4'h0);

    applyStimulus(1'b1, 4'd2, 2'b10, 8'd0);
    repeat (30) applyStimulus(1'b0, 4'd0, 2'b00, 8'd0);

    #2;
    RESET_n = 1'b0;
    #1;
    checkResetState("async_reset");
    @(posedge PCLK);
    #1;
    modelReset();
    RESET_n = 1'b1;
    runTable(14);

    repeat (300) begin
      rv  = ($urandom_range(0, 2) == 0);
      rch = 4'($urandom_range(0, 7));
      rm  = 2'($urandom_range(0, 3));
      rh  = 8'($urandom_range(0, 5));
      applyStimulus(rv, rch, rm, rh);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
